// File: rtl/drcontador_desc.sv
// Loadable synchronous down-counter with a one-cycle terminal-count strobe.
// Define DRCONTADOR_DESC_RELOAD_EN to make it reload the last loaded value at zero.
module drcontador_desc #(
   parameter int WIDTH = 11
) (
   input  logic             Clo,
   input  logic             Clr,
   input  logic             JK,
   input  logic             Load,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             Zero,
   output logic             Tc,
   output logic             Busy
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [WIDTH-1:0] ZERO_VAL = '0;
   localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] rld_q, rld_d;
   logic             tc_q, tc_d;

   always_ff @(posedge Clo or negedge Clr) begin
      if (!Clr) begin
         state_q <= IDLE;
         q_q     <= ZERO_VAL;
         rld_q   <= ZERO_VAL;
         tc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         rld_q   <= rld_d;
         tc_q    <= tc_d;
      end
   end

   // Load wins over counting; Tc is a default-low strobe so it never stretches.
   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      rld_d   = rld_q;
      tc_d    = 1'b0;
      if (Load) begin
         q_d     = D;
         rld_d   = D;
         state_d = (D != ZERO_VAL) ? RUN : IDLE;
      end else if (state_q == RUN) begin
         if (q_q == ZERO_VAL) begin
`ifdef DRCONTADOR_DESC_RELOAD_EN
            if (JK) begin
               q_d = rld_q;
            end
`else
            state_d = IDLE;
`endif
         end else if (JK) begin
            q_d  = q_q - ONE_VAL;
            tc_d = (q_q == ONE_VAL);
         end
      end
   end

   assign Q    = q_q;
   assign Zero = (q_q == ZERO_VAL);
   assign Tc   = tc_q;
   assign Busy = (state_q == RUN);

endmodule

// File: doc/drcontador_desc.md
Name: drcontador_desc

Overview:
- Synchronous, loadable down-counter with terminal-count pulse. It is the counting-down counterpart of the 11-stage JK ripple up-counter in the 4-bit adder / 7-segment project.
- Loads a start value, decrements on each enabled clock, and flags arrival at zero.
- Feeds the display/control logic with a countdown value and a one-cycle done strobe.

Parameters:
- WIDTH, 11, counter width in bits. Matches the 11-stage up-counter; legal range 2..16.

Ports:
- Clo  input  1  system clock; all state updates on rising edge.
- Clr  input  1  asynchronous, active-low reset; clears all state immediately while low.
- JK  input  1  count enable; decrement happens only when high.
- Load  input  1  synchronous load strobe.
- D  input  WIDTH  load value, sampled when Load=1.
- Q  output  WIDTH  current count, registered.
- Zero  output  1  combinational, equals (Q == 0).
- Tc  output  1  registered terminal-count pulse, one cycle wide.
- Busy  output  1  high while in state RUN.

Behaviour:
- Reset (Clr=0, asynchronous): Q=0, Rld=0, Tc=0, state=IDLE, Busy=0, Zero=1. Outputs stay at these values until the first rising Clo after Clr returns high.
- Internal register Rld (WIDTH) holds the last loaded value.
- States:
  - IDLE: Q holds; JK is ignored.
  - RUN: counting.
- Priority each cycle: Load > count > hold.
- Load=1, any state:
  - Q<=D and Rld<=D.
  - Tc<=0.
  - Next state is RUN if D!=0, otherwise IDLE.
  - Load while running restarts the count. No Tc is produced for the aborted count.
- RUN, JK=1, Q>1: Q<=Q-1, Tc<=0.
- RUN, JK=1, Q==1: Q<=0, Tc<=1. Tc is high in the same cycle that Q first reads 0.
- RUN, JK=0: Q holds and Tc<=0. Tc is never stretched.
- RUN, Q==0 (only reachable after the 1->0 step): behaviour is set by the optional feature below.
- Tc is high for exactly one cycle per 1->0 transition and is never asserted from IDLE.
- Latency: Load to Q valid is 1 cycle. From a load of N with JK held high, Tc asserts N cycles after the load edge.
- No arithmetic wrap below zero: Q never goes 0 -> all-ones.
- Load with D=0: Q=0, state IDLE, Tc stays 0.
- D is WIDTH bits; no truncation or sign handling.
- Clr asserted mid-count: immediate return to reset values. Rld is lost.

Optional Feature:
- Macro: DRCONTADOR_DESC_RELOAD_EN.
- Defined (auto-reload):
  - In RUN with Q==0 and JK=1: Q<=Rld and the state stays RUN.
  - Period is Rld+1 enabled cycles, with one Tc per period.
  - With JK=0 at Q==0, Q holds 0.
  - Busy stays high until a Load of 0 or reset.
- Undefined (one-shot):
  - In RUN with Q==0, the next edge moves to IDLE regardless of JK; Q holds 0.
  - Busy drops one cycle after Tc.
  - Rld is still written on Load but unused.

Test Plan:
- Reset: hold Clr=0 with Load=1, D=5 and clocks running -> Q=0, Tc=0, Busy=0, Zero=1. Release Clr -> values unchanged until the next Load.
- One-shot (macro undefined): Load D=3, then JK=1 -> Q=3,2,1,0 on successive cycles; Tc=1 only in the Q=0 cycle; Busy=0 the cycle after; Q stays 0 for 10 more cycles.
- Enable gating: Load D=4, toggle JK 1,0,0,1,1,1 -> Q=3,3,3,2,1,0; single Tc pulse with Q=0.
- Load priority and edge cases:
  - Load D=7, count to 4, then Load=1, D=2 with JK=1 in the same cycle -> Q=2 (no decrement that cycle), then 1, 0; no Tc at the abort.
  - Load D=0 -> Q=0, IDLE, Tc=0.
- Auto-reload (macro defined): Load D=2, JK=1 held for 9 cycles -> Q=2,1,0,2,1,0,2,1,0; Tc high in each Q=0 cycle (3 pulses); Busy stays 1.
- Width boundary: Load D=2047 (all ones, WIDTH=11), JK=1 for 2047 cycles -> Q reaches 0 with a single Tc; no underflow to 2047 in one-shot mode.
